enigma_plugboard: RTL and testbench

Steckerbrett stage of the Enigma datapath. It sits directly upstream of the first rotor (forward path) and a second instance sits directly downstream of the last return rotor. The block holds a reciprocal letter-swap table that is loaded serially, one pair per cycle. It substitutes each incoming symbol with a one-cycle registered valid/done handshake that matches the rotor stage interface.

---
 rtl/enigma_pkg.sv | 22 ++
 rtl/enigma_swap_table.sv | 49 ++++
 rtl/enigma_plugboard.sv | 92 +++++++++
 tb/tb_enigma_plugboard.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared definitions for the Enigma datapath stages: alphabet geometry,
// symbol/letter types and the plugboard configuration FSM states.
package enigma_pkg;

  localparam int N_LETTERS = 26;
  localparam int DW        = 8;
  localparam int MAX_PAIRS = 13;
  localparam int LW        = 5;

  typedef logic [LW-1:0] letter_t;
  typedef logic [DW-1:0] sym_t;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  function automatic logic is_letter(input sym_t s);
    return s < sym_t'(N_LETTERS);
  endfunction

endpackage

// File: rtl/enigma_swap_table.sv
// Reciprocal letter-swap register file: identity clear, dual-entry pair write,
// "unplugged" query on the two write addresses and one combinational read port.
module enigma_swap_table
  import enigma_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [LW-1:0] wr_a,
  input  logic [LW-1:0] wr_b,
  input  logic [LW-1:0] rd_addr,
  output logic          free_a,
  output logic          free_b,
  output logic [LW-1:0] rd_data
);

  letter_t map_q [N_LETTERS];
  letter_t map_d [N_LETTERS];

  // Queries see the table as it will look after a same-cycle clear.
  always_comb begin
    free_a  = 1'b0;
    free_b  = 1'b0;
    rd_data = '0;
    for (int i = 0; i < N_LETTERS; i++) begin
      if (wr_a == letter_t'(i)) free_a = clr || (map_q[i] == letter_t'(i));
      if (wr_b == letter_t'(i)) free_b = clr || (map_q[i] == letter_t'(i));
      if (rd_addr == letter_t'(i)) rd_data = map_q[i];
    end
  end

  always_comb begin
    for (int i = 0; i < N_LETTERS; i++) begin
      map_d[i] = clr ? letter_t'(i) : map_q[i];
      if (wr_en && (wr_a == letter_t'(i))) map_d[i] = wr_b;
      if (wr_en && (wr_b == letter_t'(i))) map_d[i] = wr_a;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_LETTERS; i++) map_q[i] <= letter_t'(i);
    end else begin
      for (int i = 0; i < N_LETTERS; i++) map_q[i] <= map_d[i];
    end
  end

endmodule

// File: rtl/enigma_plugboard.sv
// Steckerbrett stage: serial pair loading with validation in LOAD, and a
// one-cycle registered symbol substitution with valid/done handshake in RUN.
module enigma_plugboard
  import enigma_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          set,
  input  logic          cfg_valid,
  input  logic [DW-1:0] cfg_a,
  input  logic [DW-1:0] cfg_b,
  input  logic          valid,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          done,
  output logic          cfg_err,
  output logic [3:0]    pair_cnt
);

  state_t        state_q, state_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          done_q, done_d;
  logic          cfg_err_q, cfg_err_d;
  logic [3:0]    pair_cnt_q, pair_cnt_d;

  logic          entering, cfg_mode, run_mode;
  logic          free_a, free_b, pair_ok, wr_en;
  logic [3:0]    cnt_eff;
  logic [LW-1:0] rd_data;

  enigma_swap_table u_table (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (entering),
    .wr_en   (wr_en),
    .wr_a    (cfg_a[LW-1:0]),
    .wr_b    (cfg_b[LW-1:0]),
    .rd_addr (din[LW-1:0]),
    .free_a  (free_a),
    .free_b  (free_b),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      dout_q     <= '0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      pair_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dout_q     <= dout_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
      pair_cnt_q <= pair_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (set)  state_d = LOAD;
      LOAD:    if (!set) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // The set-rising cycle already behaves as LOAD, on top of a cleared table.
  always_comb begin
    entering = (state_q == RUN) && set;
    cfg_mode = (state_q == LOAD) || set;
    run_mode = (state_q == RUN) && !set;

    cnt_eff = entering ? 4'd0 : pair_cnt_q;
    pair_ok = is_letter(cfg_a) && is_letter(cfg_b) && (cfg_a != cfg_b) &&
              free_a && free_b && (cnt_eff < 4'(MAX_PAIRS));
    wr_en      = cfg_mode && cfg_valid && pair_ok;
    cfg_err_d  = cfg_mode && cfg_valid && !pair_ok;
    pair_cnt_d = cnt_eff + {3'b000, wr_en};

    done_d = valid && run_mode;
    dout_d = dout_q;
    if (done_d) dout_d = is_letter(din) ? {{(DW-LW){1'b0}}, rd_data} : din;
  end

  assign dout     = dout_q;
  assign done     = done_q;
  assign cfg_err  = cfg_err_q;
  assign pair_cnt = pair_cnt_q;

endmodule

// File: tb/tb_enigma_plugboard.sv
// Scoreboard bench for enigma_plugboard: expected symbols are queued as they
// are driven and retired against done/dout on the falling clock edge.
module tb_enigma_plugboard;
  import enigma_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n, set, cfg_valid, valid;
  logic [7:0] cfg_a, cfg_b, din, dout;
  logic       done, cfg_err;
  logic [3:0] pair_cnt;

  logic       exp_v;
  logic [7:0] exp_d, mon_e;
  logic [7:0] exp_q [$];
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  enigma_plugboard dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .set       (set),
    .cfg_valid (cfg_valid),
    .cfg_a     (cfg_a),
    .cfg_b     (cfg_b),
    .valid     (valid),
    .din       (din),
    .dout      (dout),
    .done      (done),
    .cfg_err   (cfg_err),
    .pair_cnt  (pair_cnt)
  );

  always @(posedge clk) if (reset_n && exp_v) exp_q.push_back(exp_d);

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
    end else if (done) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: got done=1 dout=%0d, want done=0", dout);
      end else begin
        mon_e = exp_q.pop_front();
        if (dout !== mon_e) begin
          n_err++;
          $display("FAIL dout: got %0d, want %0d", dout, mon_e);
        end
      end
    end else if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      mon_e = exp_q.pop_front();
      $display("FAIL missing_done: got done=0, want done=1 dout=%0d", mon_e);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    set = 1'b0; cfg_valid = 1'b0; valid = 1'b0; exp_v = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] e, input logic acc);
    valid = 1'b1; din = d; exp_v = acc; exp_d = e;
    step();
    valid = 1'b0; exp_v = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] b);
    cfg_valid = 1'b1; cfg_a = a; cfg_b = b;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; quiet(); cfg_a = '0; cfg_b = '0; din = '0; exp_d = '0;
    step(); step();
    n_vec++; if (dout !== 8'd0)     begin n_err++; $display("FAIL rst_dout: got %0d, want 0", dout); end
    n_vec++; if (done !== 1'b0)     begin n_err++; $display("FAIL rst_done: got %0b, want 0", done); end
    n_vec++; if (cfg_err !== 1'b0)  begin n_err++; $display("FAIL rst_cfg_err: got %0b, want 0", cfg_err); end
    n_vec++; if (pair_cnt !== 4'd0) begin n_err++; $display("FAIL rst_pair_cnt: got %0d, want 0", pair_cnt); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_identity();
    for (int i = 0; i < N_LETTERS; i++) begin
      valid = 1'b1; din = 8'(i); exp_v = 1'b1; exp_d = 8'(i);
      step();
    end
    quiet(); step(); step();
  endtask

  task automatic test_pairs();
    logic [7:0] pd [5] = '{8'd0, 8'd25, 8'd4, 8'd7, 8'd3};
    logic [7:0] pe [5] = '{8'd25, 8'd0, 8'd7, 8'd4, 8'd3};
    set = 1'b1;
    wr(8'd0, 8'd25);
    n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL entry_write_err: got %0b, want 0", cfg_err); end
    wr(8'd4, 8'd7);
    n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL pair_write_err: got %0b, want 0", cfg_err); end
    set = 1'b0;
    step();
    n_vec++; if (pair_cnt !== 4'd2) begin n_err++; $display("FAIL pair_cnt_two: got %0d, want 2", pair_cnt); end
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1; din = pd[i]; exp_v = 1'b1; exp_d = pe[i];
      step();
    end
    send(8'd200, 8'd200, 1'b1);
    quiet(); step(); step();
  endtask

  task automatic test_reject();
    set = 1'b1;
    step();
    wr(8'd4, 8'd7);
    n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL rej_first_ok: got %0b, want 0", cfg_err); end
    wr(8'd7, 8'd9);
    n_vec++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL rej_plugged: got %0b, want 1", cfg_err); end
    step();
    n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL rej_pulse_len: got %0b, want 0", cfg_err); end
    n_vec++; if (pair_cnt !== 4'd1) begin n_err++; $display("FAIL rej_pair_cnt: got %0d, want 1", pair_cnt); end
    wr(8'd5, 8'd5);
    n_vec++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL rej_same: got %0b, want 1", cfg_err); end
    wr(8'd30, 8'd2);
    n_vec++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL rej_range: got %0b, want 1", cfg_err); end
    set = 1'b0;
    step();
    n_vec++; if (pair_cnt !== 4'd1) begin n_err++; $display("FAIL rej_pair_cnt_end: got %0d, want 1", pair_cnt); end
    send(8'd9, 8'd9, 1'b1);
    send(8'd7, 8'd4, 1'b1);
    send(8'd4, 8'd7, 1'b1);
    send(8'd2, 8'd2, 1'b1);
    quiet(); step(); step();
  endtask

  task automatic test_max_pairs();
    set = 1'b1;
    for (int i = 0; i < MAX_PAIRS; i++) begin
      wr(8'(2 * i), 8'(2 * i + 1));
      if (cfg_err !== 1'b0) begin
        n_err++; $display("FAIL max_fill_err: pair %0d got %0b, want 0", i, cfg_err);
      end
      n_vec++;
    end
    wr(8'd3, 8'd20);
    n_vec++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL max_14th: got %0b, want 1", cfg_err); end
    n_vec++; if (pair_cnt !== 4'd13) begin n_err++; $display("FAIL max_pair_cnt: got %0d, want 13", pair_cnt); end
    set = 1'b0;
    step();
    send(8'd0, 8'd1, 1'b1);
    send(8'd25, 8'd24, 1'b1);
    send(8'd12, 8'd13, 1'b1);
    quiet(); step(); step();
  endtask

  task automatic test_set_during_run();
    valid = 1'b1; din = 8'd3; exp_v = 1'b1; exp_d = 8'd2;
    step(); step();
    set = 1'b1; exp_v = 1'b0;
    step(); step(); step();
    set = 1'b0; din = 8'd0;
    step();
    n_vec++; if (pair_cnt !== 4'd0) begin n_err++; $display("FAIL set_pair_cnt: got %0d, want 0", pair_cnt); end
    exp_v = 1'b1; exp_d = 8'd0;
    step();
    send(8'd3, 8'd3, 1'b1);
    send(8'd200, 8'd200, 1'b1);
    quiet(); step(); step();
  endtask

  task automatic test_reset_mid_load();
    set = 1'b1;
    wr(8'd1, 8'd2);
    wr(8'd3, 8'd4);
    wr(8'd1, 8'd1);
    n_vec++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL mid_err_pre: got %0b, want 1", cfg_err); end
    n_vec++; if (pair_cnt !== 4'd2) begin n_err++; $display("FAIL mid_cnt_pre: got %0d, want 2", pair_cnt); end
    reset_n = 1'b0;
    #1;
    n_vec++; if (cfg_err !== 1'b0)  begin n_err++; $display("FAIL mid_cfg_err: got %0b, want 0", cfg_err); end
    n_vec++; if (done !== 1'b0)     begin n_err++; $display("FAIL mid_done: got %0b, want 0", done); end
    n_vec++; if (pair_cnt !== 4'd0) begin n_err++; $display("FAIL mid_pair_cnt: got %0d, want 0", pair_cnt); end
    n_vec++; if (dout !== 8'd0)     begin n_err++; $display("FAIL mid_dout: got %0d, want 0", dout); end
    set = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    send(8'd1, 8'd1, 1'b1);
    send(8'd2, 8'd2, 1'b1);
    send(8'd0, 8'd0, 1'b1);
    quiet(); step(); step();
  endtask

  initial begin
    test_reset();
    test_identity();
    test_pairs();
    test_reject();
    test_max_pairs();
    test_set_during_run();
    test_reset_mid_load();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
